// File: rtl/crp16_alu_shift_seq_pkg.sv
// Operation and FSM state encodings plus fixed datapath widths shared by the
// CRP16 ALU shift path.
package crp16_alu_shift_seq_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    localparam logic [1:0] SHOP_SRL = 2'b00;
    localparam logic [1:0] SHOP_SRA = 2'b01;
    localparam logic [1:0] SHOP_SLL = 2'b10;
    localparam logic [1:0] SHOP_ROR = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_P1   = 2'd1;
    localparam logic [1:0] ST_P2   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/crp16_alu_shift_seq_bitrev.sv
// 16-bit bit reversal (bit i <-> bit 15-i) around the right shifter.
// Purely combinational: zero latency, no flow control.
module crp16_bit_reverse_16
    import crp16_alu_shift_seq_pkg::*;
(
    input  logic [DATA_W-1:0] i_x,
    output logic [DATA_W-1:0] o_y
);

    for (genvar g = 0; g < DATA_W; g++) begin : g_rev
        assign o_y[g] = i_x[DATA_W-1-g];
    end

endmodule

// File: rtl/crp16_alu_shift_seq_shifter.sv
// 16-bit right barrel shifter, logical or arithmetic (log_ar=1 sign-fills).
// Purely combinational: zero latency, no flow control.
module crp16_alu_shifter_right
    import crp16_alu_shift_seq_pkg::*;
(
    input  logic [DATA_W-1:0] i_x,
    input  logic [AMT_W-1:0]  i_shift,
    input  logic              i_log_ar,
    output logic [DATA_W-1:0] o_out
);

    logic [DATA_W-1:0] w_fill;

    // Vacated high bits are filled with the sign only for arithmetic shifts.
    assign w_fill = {DATA_W{i_log_ar & i_x[DATA_W-1]}};
    assign o_out  = (i_x >> i_shift) | (w_fill & ~({DATA_W{1'b1}} >> i_shift));

endmodule

// File: rtl/crp16_alu_shift_seq.sv
// Shift sequencer ahead of crp16_alu_shifter_right; accept-to-valid 2 edges (ROR 3), 1 for amt==0 under CRP16_SHIFT_BYPASS_EN.
// One command in flight: in_ready only in IDLE; result/flags held in DONE until out_ready.
module crp16_alu_shift_seq
    import crp16_alu_shift_seq_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] x,
    input  logic [AMT_W-1:0]  amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c
);

    logic [1:0]        r_state;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_x;
    logic [AMT_W-1:0]  r_amt;
    logic [DATA_W-1:0] r_result;
    logic              r_flag_z;
    logic              r_flag_n;
    logic              r_flag_c;

    logic              w_p2;
    logic              w_amt_nz;
    logic [DATA_W-1:0] w_rev_in;
    logic [DATA_W-1:0] w_sh_x;
    logic [AMT_W-1:0]  w_sh_shift;
    logic              w_sh_log_ar;
    logic [DATA_W-1:0] w_sh_out;
    logic [DATA_W-1:0] w_rev_out;
    logic [DATA_W-1:0] w_p1_val;
    logic [DATA_W-1:0] w_p2_val;
    logic [AMT_W-1:0]  w_idx_lo;
    logic [AMT_W-1:0]  w_idx_hi;
    logic              w_p1_c;

    assign w_p2     = (r_state == ST_P2);
    assign w_amt_nz = (r_amt != 4'd0);

    crp16_bit_reverse_16 u_rev_in (
        .i_x (r_x),
        .o_y (w_rev_in)
    );

    // Left shifts and the second ROR pass run the right shifter on reversed data;
    // the P2 amount 16-amt wraps naturally in AMT_W bits.
    assign w_sh_x      = (w_p2 || (r_op == SHOP_SLL)) ? w_rev_in : r_x;
    assign w_sh_shift  = w_p2 ? (4'd0 - r_amt) : r_amt;
    assign w_sh_log_ar = !w_p2 && (r_op == SHOP_SRA);

    crp16_alu_shifter_right u_shifter (
        .i_x      (w_sh_x),
        .i_shift  (w_sh_shift),
        .i_log_ar (w_sh_log_ar),
        .o_out    (w_sh_out)
    );

    crp16_bit_reverse_16 u_rev_out (
        .i_x (w_sh_out),
        .o_y (w_rev_out)
    );

    assign w_p1_val = (r_op == SHOP_SLL) ? w_rev_out : w_sh_out;
    assign w_p2_val = r_result | w_rev_out;

    assign w_idx_lo = r_amt - 4'd1;
    assign w_idx_hi = 4'd0 - r_amt;

    always_comb begin
        w_p1_c = 1'b0;
        if (w_amt_nz) begin
            case (r_op)
                SHOP_SRL, SHOP_SRA: w_p1_c = r_x[w_idx_lo];
                SHOP_SLL:           w_p1_c = r_x[w_idx_hi];
                default:            w_p1_c = w_p1_val[DATA_W-1];
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_op     <= 2'b00;
            r_x      <= '0;
            r_amt    <= '0;
            r_result <= '0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op  <= op;
                        r_x   <= x;
                        r_amt <= amt;
`ifdef CRP16_SHIFT_BYPASS_EN
                        if (amt == 4'd0) begin
                            r_result <= x;
                            r_flag_z <= (x == '0);
                            r_flag_n <= x[DATA_W-1];
                            r_flag_c <= 1'b0;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_P1;
                        end
`else
                        r_state <= ST_P1;
`endif
                    end
                end
                ST_P1: begin
                    r_result <= w_p1_val;
                    if ((r_op == SHOP_ROR) && w_amt_nz) begin
                        r_state <= ST_P2;
                    end else begin
                        r_flag_z <= (w_p1_val == '0);
                        r_flag_n <= w_p1_val[DATA_W-1];
                        r_flag_c <= w_p1_c;
                        r_state  <= ST_DONE;
                    end
                end
                ST_P2: begin
                    r_result <= w_p2_val;
                    r_flag_z <= (w_p2_val == '0);
                    r_flag_n <= w_p2_val[DATA_W-1];
                    r_flag_c <= w_p2_val[DATA_W-1];
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign flag_z    = r_flag_z;
    assign flag_n    = r_flag_n;
    assign flag_c    = r_flag_c;

endmodule

// File: tb/tb_crp16_alu_shift_seq.sv
// Bench for crp16_alu_shift_seq: directed vectors, amt==0 corner, backpressure,
// mid-operation reset and randomized commands against a behavioural model.
module tb_crp16_alu_shift_seq;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] x;
    logic [3:0]  amt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;

    int n_checks = 0;
    int n_fail   = 0;

    crp16_alu_shift_seq dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .amt       (amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: {result, z, n, c} from plain arithmetic on the operation definitions.
    function automatic logic [18:0] model(input logic [1:0] m_op, input logic [15:0] m_x,
                                          input logic [3:0] m_amt);
        logic [31:0] wide;
        logic [15:0] r;
        logic        c;
        int          k;
        k = int'(m_amt);
        case (m_op)
            2'b00: r = m_x >> m_amt;
            2'b01: r = $signed(m_x) >>> m_amt;
            2'b10: r = m_x << m_amt;
            default: begin
                wide = {m_x, m_x} >> m_amt;
                r = wide[15:0];
            end
        endcase
        c = 1'b0;
        if (k != 0) begin
            case (m_op)
                2'b00, 2'b01: c = m_x[k-1];
                2'b10:        c = m_x[16-k];
                default:      c = r[15];
            endcase
        end
        return {r, (r == 16'h0000), r[15], c};
    endfunction

    function automatic int exp_lat(input logic [1:0] m_op, input logic [3:0] m_amt);
`ifdef CRP16_SHIFT_BYPASS_EN
        if (m_amt == 4'd0) return 1;
`endif
        if (m_op == 2'b11 && m_amt != 4'd0) return 3;
        return 2;
    endfunction

    // Presents one command, returns edges from accept edge until out_valid is seen.
    task automatic start_cmd(input logic [1:0] c_op, input logic [15:0] c_x,
                             input logic [3:0] c_amt, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clock); #1; w++;
        end
        in_valid = 1'b1; op = c_op; x = c_x; amt = c_amt;
        @(posedge clock);
        lat = 1;
        #1;
        in_valid = 1'b0;
        op = 2'($urandom); x = 16'($urandom); amt = 4'($urandom);
        while (!out_valid && lat < 10) begin
            @(posedge clock); lat++; #1;
        end
    endtask

    task automatic do_cmd(input logic [1:0] c_op, input logic [15:0] c_x, input logic [3:0] c_amt,
                          input int hold, output logic [18:0] obs, output int lat);
        start_cmd(c_op, c_x, c_amt, lat);
        repeat (hold) begin
            @(posedge clock); #1;
        end
        obs = {result, flag_z, flag_n, flag_c};
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; x = 16'h0; amt = 4'h0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if ({result, flag_z, flag_n, flag_c} !== 19'h0) begin
            n_fail++; $display("FAIL reset_outputs: got result=%h znc=%b%b%b want 0000 000", result, flag_z, flag_n, flag_c);
        end
        @(negedge clock) resetn = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [5]  = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b11};
        logic [15:0] t_x  [5]  = '{16'h8F00, 16'h0003, 16'h0001, 16'h1234, 16'h0001};
        logic [3:0]  t_amt[5]  = '{4'd4, 4'd15, 4'd1, 4'd4, 4'd1};
        logic [18:0] t_exp[5]  = '{{16'hF8F0, 3'b010}, {16'h8000, 3'b011}, {16'h0000, 3'b101},
                                   {16'h4123, 3'b000}, {16'h8000, 3'b011}};
        int          t_lat[5]  = '{2, 2, 2, 3, 3};
        logic [18:0] obs;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            do_cmd(t_op[i], t_x[i], t_amt[i], 0, obs, lat);
            n_checks++; if (obs !== t_exp[i]) begin
                n_fail++; $display("FAIL directed_%0d: got res/znc %h/%b want %h/%b", i, obs[18:3], obs[2:0], t_exp[i][18:3], t_exp[i][2:0]);
            end
            n_checks++; if (lat !== t_lat[i]) begin
                n_fail++; $display("FAIL directed_lat_%0d: got %0d want %0d", i, lat, t_lat[i]);
            end
        end
    endtask

    task automatic test_amt_zero();
        logic [18:0] obs;
        logic [15:0] d;
        int          lat;
        for (int o = 0; o < 4; o++) begin
            d = 16'($urandom) | 16'h8000;
            if (o == 2) d = 16'h0000;
            do_cmd(2'(o), d, 4'd0, 0, obs, lat);
            n_checks++; if (obs !== {d, (d == 16'h0), d[15], 1'b0}) begin
                n_fail++; $display("FAIL amt0_op%0d: got res/znc %h/%b want %h/%b%b0", o, obs[18:3], obs[2:0], d, (d == 16'h0), d[15]);
            end
            n_checks++; if (lat !== exp_lat(2'(o), 4'd0)) begin
                n_fail++; $display("FAIL amt0_lat_op%0d: got %0d want %0d", o, lat, exp_lat(2'(o), 4'd0));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] exp1;
        logic [18:0] exp2;
        logic [18:0] obs;
        int          lat;
        exp1 = model(2'b10, 16'h1234, 4'd3);
        exp2 = model(2'b00, 16'hFFFF, 4'd1);
        start_cmd(2'b10, 16'h1234, 4'd3, lat);
        in_valid = 1'b1; op = 2'b00; x = 16'hFFFF; amt = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            n_checks++; if ({result, flag_z, flag_n, flag_c} !== exp1) begin
                n_fail++; $display("FAIL bp_hold_%0d: got %h/%b%b%b want %h/%b", i, result, flag_z, flag_n, flag_c, exp1[18:3], exp1[2:0]);
            end
            n_checks++; if ({out_valid, in_ready} !== 2'b10) begin
                n_fail++; $display("FAIL bp_hs_%0d: got valid/ready %b%b want 10", i, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        n_checks++; if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_release: got valid/ready %b%b want 01", out_valid, in_ready);
        end
        @(posedge clock);
        lat = 1;
        #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(posedge clock); lat++; #1;
        end
        obs = {result, flag_z, flag_n, flag_c};
        n_checks++; if (obs !== exp2) begin
            n_fail++; $display("FAIL bp_next_cmd: got %h/%b want %h/%b", obs[18:3], obs[2:0], exp2[18:3], exp2[2:0]);
        end
        n_checks++; if (lat !== 2) begin
            n_fail++; $display("FAIL bp_next_lat: got %0d want 2", lat);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [18:0] obs;
        int          lat;
        in_valid = 1'b1; op = 2'b11; x = 16'h1234; amt = 4'd4;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #2;
        resetn = 1'b0;
        #1;
        n_checks++; if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL midrst_hs: got ready/valid %b%b want 10", in_ready, out_valid);
        end
        n_checks++; if ({result, flag_z, flag_n, flag_c} !== 19'h0) begin
            n_fail++; $display("FAIL midrst_outputs: got %h/%b%b%b want 0000/000", result, flag_z, flag_n, flag_c);
        end
        @(negedge clock) resetn = 1'b1;
        @(posedge clock); #1;
        do_cmd(2'b00, 16'hFFFF, 4'd8, 0, obs, lat);
        n_checks++; if (obs !== {16'h00FF, 3'b001}) begin
            n_fail++; $display("FAIL midrst_fresh: got %h/%b want 00ff/001", obs[18:3], obs[2:0]);
        end
        n_checks++; if (lat !== 2) begin
            n_fail++; $display("FAIL midrst_lat: got %0d want 2", lat);
        end
    endtask

    task automatic test_random();
        logic [1:0]  r_op;
        logic [15:0] r_x;
        logic [3:0]  r_amt;
        logic [18:0] obs;
        logic [18:0] expv;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            r_op  = 2'($urandom);
            r_x   = 16'($urandom);
            r_amt = 4'($urandom);
            if (i % 10 == 0) r_amt = 4'd15;
            if (i % 10 == 5) r_x = 16'h8000 | 16'($urandom_range(0, 3));
            expv = model(r_op, r_x, r_amt);
            do_cmd(r_op, r_x, r_amt, $urandom_range(0, 3), obs, lat);
            n_checks++; if (obs !== expv) begin
                n_fail++; $display("FAIL rand_%0d op=%0d x=%h amt=%0d: got %h/%b want %h/%b", i, r_op, r_x, r_amt, obs[18:3], obs[2:0], expv[18:3], expv[2:0]);
            end
            n_checks++; if (lat !== exp_lat(r_op, r_amt)) begin
                n_fail++; $display("FAIL rand_lat_%0d op=%0d amt=%0d: got %0d want %0d", i, r_op, r_amt, lat, exp_lat(r_op, r_amt));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_amt_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
